mux_arb_nx1: RTL and testbench
==============================

# mux_arb_nx1

Parametrised N-to-1 streaming multiplexer with per-channel valid/ready handshakes and a registered output stage. It is the next generation of the team's fixed 4-bit 4:1 mux. Channel choice comes either from an explicit select (manual mode) or from an internal round-robin arbiter. It sits between several producer streams and a single consumer, for example a shared datapath or bus port.

## Interface
- `WIDTH`, default 4: data width per channel, ≥1.
- `CH`, default 4: number of input channels, ≥2. `SELW = $clog2(CH)` is derived and is not overridable.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_data`  in  CH*WIDTH: channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `in_valid`  in  CH: per-channel valid.
- `in_ready`  out  CH: per-channel ready; combinational.
- `mode`  in  1: 0 = manual (`sel`), 1 = round-robin.
- `sel`  in  SELW: channel index used in manual mode.
- `out_data`  out  WIDTH: registered output data.
- `out_valid`  out  1: output holds a beat.
- `out_ready`  in  1: consumer accepts the beat.
- `grant`  out  SELW: source channel of the beat in `out_data`.
- `in_last` / `out_last`  in CH / out 1: present only with `MUX_ARB_LAST_EN`.

## Operation
- **Output register.** The block has a one-entry output register.
- **Load condition.** `load_ok = !out_valid || out_ready`.
- **Manual mode (`mode=0`).**
  - Chosen channel `c = sel`.
  - `in_ready[c] = load_ok`; all other `in_ready` are 0.
  - If `sel >= CH` (non-power-of-two CH), no channel is chosen, all `in_ready` are 0, and nothing is accepted.
- **Round-robin mode (`mode=1`).**
  - `ptr` holds the last granted index.
  - Search order is `ptr+1, ptr+2, … ptr`, modulo CH.
  - `c` is the first channel with `in_valid` set.
  - `in_ready[c] = load_ok`; all others are 0. If no channel is valid, all `in_ready` are 0.
- **Accept.** An accept occurs when `in_valid[c] && in_ready[c]`. On accept:
  - `out_data <= in_data[c]`, `grant <= c`, `out_valid <= 1`.
  - In round-robin mode only, `ptr <= c`.
- **Drain.** If `out_valid && out_ready` with no accept in the same cycle, `out_valid <= 0`. `out_data` and `grant` hold their last values.
- **Simultaneous drain and accept.** The new beat replaces the old one in the same edge, with no bubble.
- **Handshake rules.**
  - `in_ready` never depends on `in_valid` of the same channel in manual mode.
  - Producers must not drop `in_valid` or change data before an accept.
  - Consumers see `out_data` stable while `out_valid && !out_ready`.
- **Mode and select changes.** `mode` and `sel` are sampled every cycle and affect only the next accept. A beat already in the output register is never altered.
- **Reset mid-operation.** The held beat is discarded. `ptr` and the lock state reinitialise.

## Timing
- Latency: 1 cycle from accept edge to `out_valid=1`.
- Throughput: 1 beat/cycle while `out_ready=1`.
- `in_ready` is combinational from `mode`, `sel`, `in_valid` (round-robin only), `out_valid`, `out_ready` and `ptr`.
- Reset values:
  - `out_valid=0`, `out_data=0`, `grant=0`, `out_last=0`.
  - `ptr=CH-1`, so channel 0 has first priority after reset.
  - Lock state = 0.
  - All `in_ready=0` while `rst_n=0`.
- Round-robin fairness: with all channels continuously valid and `out_ready=1`, grants follow 0,1,…,CH-1,0 on consecutive cycles.

## Configuration
- **`MUX_ARB_LAST_EN` defined.**
  - Adds the `in_last[CH]` and `out_last` ports.
  - `out_last` is registered alongside `out_data`.
  - In round-robin mode, the grant locks to channel c after accepting a beat with `in_last[c]=0`.
  - While locked, only c may be granted: other channels see `in_ready=0` even if c is idle.
  - The lock releases on accepting a beat with `in_last[c]=1`; the next accept then searches from `c+1`.
  - `mode=0` clears the lock immediately. Manual mode ignores locking.
- **`MUX_ARB_LAST_EN` not defined.**
  - The `in_last` and `out_last` ports are absent.
  - Arbitration happens on every beat with no lock state.

## Test plan
- **Reset.** Assert `rst_n=0` mid-stream with `out_valid=1` → `out_valid=0`, `out_data=0`, `grant=0`, all `in_ready=0`. After release, the first round-robin grant goes to channel 0.
- **Manual select, CH=4, WIDTH=4.**
  - Stimulus: `mode=0`, `sel=2`, `in_data` channels 0–3 = 0xA, 0xB, 0xC, 0xD, all valid, `out_ready=1`.
  - Response: only `in_ready[2]=1`; `out_data=0xC` and `grant=2` one cycle later.
  - Then `sel=3` → the next beat is 0xD.
- **Round-robin fairness.** All valid, `mode=1`, `out_ready=1` for 8 cycles → grant sequence 0,1,2,3,0,1,2,3. Only channels 1 and 3 valid → 1,3,1,3.
- **Backpressure.**
  - `out_ready=0` with a beat held → all `in_ready=0`; `out_data` stable for 5 cycles.
  - Raise `out_ready` → the next beat loads on the same edge the held beat drains, with no bubble.
- **Invalid select.** CH=3, `sel=3` → all `in_ready=0`; `out_valid` falls after drain and stays 0.
- **Packet lock (`MUX_ARB_LAST_EN`).**
  - Stimulus: channel 1 sends 3 beats with `in_last` = 0,0,1 while channel 2 is continuously valid.
  - Response: grants are 1,1,1, then 2, and `out_last=1` on the third beat.
  - With the macro undefined, the same stimulus interleaves grants 1,2,1,2.

Source files
------------

// File: rtl/mux_arb_nx1.sv
// mux_arb_nx1 -- parametrised N-to-1 streaming multiplexer with a one-entry
// registered output stage. The channel is chosen either by an explicit select
// (mode=0) or by a round-robin arbiter (mode=1).
//
// Optional feature: define MUX_ARB_LAST_EN to add in_last/out_last ports and
// packet locking in round-robin mode (grant sticks to a channel until a beat
// with in_last=1 is accepted from it).
//
// Handshake: an input beat transfers on channel i at a rising clk edge when
// in_valid[i] && in_ready[i]; the output beat transfers when
// out_valid && out_ready. Producers hold valid/data until accepted; the output
// register is only overwritten when empty or draining in the same cycle.
module mux_arb_nx1 #(
  parameter int WIDTH = 4,
  parameter int CH    = 4,
  localparam int SELW = $clog2(CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH*WIDTH-1:0] in_data,
  input  logic [CH-1:0]       in_valid,
  output logic [CH-1:0]       in_ready,
`ifdef MUX_ARB_LAST_EN
  input  logic [CH-1:0]       in_last,
  output logic                out_last,
`endif
  input  logic                mode,
  input  logic [SELW-1:0]     sel,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SELW-1:0]     grant
);

  localparam logic [SELW:0]   CH_W     = (SELW+1)'(CH);
  localparam logic [SELW-1:0] PTR_INIT = SELW'(CH - 1);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  grant_q, grant_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             load_ok;
  logic             pick_vld;
  logic [SELW-1:0]  pick_ch;
  logic [WIDTH-1:0] pick_data;
  logic             accept;

`ifdef MUX_ARB_LAST_EN
  logic             lock_q, lock_d;
  logic             out_last_q, out_last_d;
  logic             pick_last;
`endif

  // The output register can take a new beat when empty or draining this cycle.
  assign load_ok = !out_valid_q || out_ready;

  // Choose the candidate channel: explicit select, locked channel, or the first
  // valid channel searching upward from the one after the last grant.
  always_comb begin
    pick_vld = 1'b0;
    pick_ch  = '0;
    if (!mode) begin
      if ({1'b0, sel} < CH_W) begin
        pick_vld = 1'b1;
        pick_ch  = sel;
      end
    end else begin
`ifdef MUX_ARB_LAST_EN
      if (lock_q) begin
        pick_vld = 1'b1;
        pick_ch  = ptr_q;
      end
`endif
      for (int i = 0; i < CH; i++) begin
        if (!pick_vld && in_valid[i] && (SELW'(i) > ptr_q)) begin
          pick_vld = 1'b1;
          pick_ch  = SELW'(i);
        end
      end
      for (int i = 0; i < CH; i++) begin
        if (!pick_vld && in_valid[i] && (SELW'(i) <= ptr_q)) begin
          pick_vld = 1'b1;
          pick_ch  = SELW'(i);
        end
      end
    end
  end

  // Steer the chosen channel's payload and raise its ready; ready is held low
  // while reset is asserted.
  always_comb begin
    pick_data = '0;
`ifdef MUX_ARB_LAST_EN
    pick_last = 1'b0;
`endif
    for (int i = 0; i < CH; i++) begin
      in_ready[i] = rst_n && pick_vld && load_ok && (pick_ch == SELW'(i));
      if (pick_ch == SELW'(i)) begin
        pick_data = in_data[i*WIDTH +: WIDTH];
`ifdef MUX_ARB_LAST_EN
        pick_last = in_last[i];
`endif
      end
    end
  end

  assign accept = |(in_valid & in_ready);

  // Next state of the output register, arbiter pointer and packet lock.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_data_d  = pick_data;
      out_valid_d = 1'b1;
      grant_d     = pick_ch;
      if (mode) begin
        ptr_d = pick_ch;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
`ifdef MUX_ARB_LAST_EN
    out_last_d = out_last_q;
    lock_d     = lock_q;
    if (accept) begin
      out_last_d = pick_last;
    end
    if (!mode) begin
      lock_d = 1'b0;
    end else if (accept) begin
      lock_d = !pick_last;
    end
`endif
  end

  // State registers; reset discards any held beat and restarts arbitration
  // so channel 0 has first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      grant_q     <= '0;
      ptr_q       <= PTR_INIT;
`ifdef MUX_ARB_LAST_EN
      out_last_q  <= 1'b0;
      lock_q      <= 1'b0;
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
`ifdef MUX_ARB_LAST_EN
      out_last_q  <= out_last_d;
      lock_q      <= lock_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign grant     = grant_q;
`ifdef MUX_ARB_LAST_EN
  assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_mux_arb_nx1.sv
// tb_mux_arb_nx1 -- bench for mux_arb_nx1 (CH=4 main instance, CH=3 instance
// for the out-of-range select case). Builds with or without MUX_ARB_LAST_EN.
module tb_mux_arb_nx1;

  localparam int WIDTH = 4;
  localparam int CH    = 4;
  localparam int SELW  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [CH*WIDTH-1:0] in_data;
  logic [CH-1:0]       in_valid, in_ready;
  logic                mode;
  logic [SELW-1:0]     sel;
  logic [WIDTH-1:0]    out_data;
  logic                out_valid, out_ready;
  logic [SELW-1:0]     grant;

  logic [3*WIDTH-1:0]  in_data3;
  logic [2:0]          in_valid3, in_ready3;
  logic [1:0]          sel3;
  logic [WIDTH-1:0]    out_data3;
  logic                out_valid3;
  logic [1:0]          grant3;

`ifdef MUX_ARB_LAST_EN
  logic [CH-1:0]       in_last;
  logic                out_last;
  logic [2:0]          in_last3;
  logic                out_last3;
`endif

  mux_arb_nx1 #(.WIDTH(WIDTH), .CH(CH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready),
`ifdef MUX_ARB_LAST_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .grant(grant)
  );

  mux_arb_nx1 #(.WIDTH(WIDTH), .CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3),
`ifdef MUX_ARB_LAST_EN
    .in_last(in_last3), .out_last(out_last3),
`endif
    .mode(mode), .sel(sel3), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready), .grant(grant3)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: abstract state of the mux (held beat, last grant, lock).
  int m_ptr;
  bit m_valid;
  int m_data;
  int m_grant;
  bit m_lock;
  bit m_last;
  int m_acc;   // channel accepted on the most recent edge, -1 if none

  task automatic model_reset();
    m_ptr = CH - 1; m_valid = 0; m_data = 0; m_grant = 0;
    m_lock = 0; m_last = 0; m_acc = -1;
  endtask

  function automatic int model_pick();
    if (!mode) return (int'(sel) < CH) ? int'(sel) : -1;
    if (m_lock) return m_ptr;
    for (int k = 1; k <= CH; k++) begin
      int j = (m_ptr + k) % CH;
      if (in_valid[j[SELW-1:0]]) return j;
    end
    return -1;
  endfunction

  // One clock cycle: compare DUT to model on the falling edge, advance model.
  task automatic step();
    int pick;
    bit load_ok, acc;
    logic [CH-1:0] exp_ready;
    @(negedge clk);
    pick      = model_pick();
    load_ok   = !m_valid || out_ready;
    exp_ready = '0;
    if (pick >= 0 && load_ok) exp_ready = CH'(1) << pick;
    check_eq("in_ready", in_ready, exp_ready);
    check_eq("out_valid", out_valid, m_valid);
    check_eq("out_data", out_data, m_data);
    check_eq("grant", grant, m_grant);
`ifdef MUX_ARB_LAST_EN
    check_eq("out_last", out_last, m_last);
`endif
    acc   = (pick >= 0) && load_ok && in_valid[pick[SELW-1:0]];
    m_acc = acc ? pick : -1;
    if (acc) begin
      m_data  = int'(WIDTH'(in_data >> (pick * WIDTH)));
      m_grant = pick;
      m_valid = 1;
      if (mode) m_ptr = pick;
`ifdef MUX_ARB_LAST_EN
      m_last = in_last[pick[SELW-1:0]];
      if (mode) m_lock = !in_last[pick[SELW-1:0]];
`endif
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    if (!mode) m_lock = 0;
    @(posedge clk);
    #1;
  endtask

  // Producers: refresh a channel only when idle or just accepted.
  task automatic refresh_channels();
    for (int i = 0; i < CH; i++) begin
      if (!in_valid[i] || m_acc == i) begin
        in_valid[i] = ($urandom_range(0, 3) != 0);
        in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
`ifdef MUX_ARB_LAST_EN
        in_last[i] = ($urandom_range(0, 2) == 0);
`endif
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  int exp_pkt[4];
  int ch1_beat;

  initial begin
    rst_n = 1'b0; mode = 1'b1; sel = '0; out_ready = 1'b1;
    in_valid = '1; in_data = {4'hD, 4'hC, 4'hB, 4'hA};
    in_valid3 = '0; in_data3 = '0; sel3 = '0;
`ifdef MUX_ARB_LAST_EN
    in_last = '1; in_last3 = '1;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", in_ready, 4'b0000);
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_data", out_data, 4'h0);
    check_eq("rst_grant", grant, 2'd0);
    rst_n = 1'b1;

    // Round-robin fairness, all channels valid.
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("rr_all", grant, i % CH);
    end
    // Only channels 1 and 3 valid.
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("rr_13", grant, (i % 2 == 0) ? 1 : 3);
    end

    // Manual select.
    mode = 1'b0; sel = 2'd2; in_valid = '1;
    #1;
    check_eq("man_ready", in_ready, 4'b0100);
    step();
    check_eq("man_data2", out_data, 4'hC);
    check_eq("man_grant2", grant, 2'd2);
    sel = 2'd3;
    step();
    check_eq("man_data3", out_data, 4'hD);

    // Backpressure: beat 0xD held for 5 cycles, then drain + load together.
    out_ready = 1'b0; sel = 2'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bp_ready", in_ready, 4'b0000);
      check_eq("bp_data", out_data, 4'hD);
    end
    out_ready = 1'b1;
    step();
    check_eq("bp_nobubble_v", out_valid, 1'b1);
    check_eq("bp_nobubble_d", out_data, 4'hA);

    // Packet stimulus: ch1 sends 3 beats (last 0,0,1), ch2 always valid.
    do_reset();
    mode = 1'b1; in_valid = 4'b0110; ch1_beat = 0;
    in_data[1*WIDTH +: WIDTH] = 4'h1;
    in_data[2*WIDTH +: WIDTH] = 4'h7;
`ifdef MUX_ARB_LAST_EN
    in_last = 4'b0100;
    exp_pkt = '{1, 1, 1, 2};
`else
    exp_pkt = '{1, 2, 1, 2};
`endif
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("pkt_grant", grant, exp_pkt[i]);
`ifdef MUX_ARB_LAST_EN
      if (i == 2) check_eq("pkt_last", out_last, 1'b1);
`endif
      if (m_acc == 1) begin
        ch1_beat++;
        in_data[1*WIDTH +: WIDTH] = WIDTH'(ch1_beat + 1);
`ifdef MUX_ARB_LAST_EN
        in_last[1] = (ch1_beat == 2);
`endif
        if (ch1_beat == 3) in_valid[1] = 1'b0;
      end
    end

    // Reset mid-stream with a beat held.
    in_valid = '1;
`ifdef MUX_ARB_LAST_EN
    in_last = '1;
`endif
    step(); step();
    check_eq("mid_valid_pre", out_valid, 1'b1);
    rst_n = 1'b0;
    #2;
    check_eq("mid_valid", out_valid, 1'b0);
    check_eq("mid_data", out_data, 4'h0);
    check_eq("mid_grant", grant, 2'd0);
    check_eq("mid_ready", in_ready, 4'b0000);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    check_eq("mid_first", grant, 2'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 7) == 0) sel = SELW'($urandom_range(0, CH - 1));
      step();
      refresh_channels();
    end

    // Out-of-range select on the CH=3 instance.
    mode = 1'b0; out_ready = 1'b1; sel3 = 2'd0;
    in_valid3 = 3'b111; in_data3 = {4'h3, 4'h2, 4'h5};
    #1;
    check_eq("ch3_ready0", in_ready3, 3'b001);
    @(posedge clk); #1;
    check_eq("ch3_load", out_valid3, 1'b1);
    check_eq("ch3_data", out_data3, 4'h5);
    sel3 = 2'd3;
    #1;
    check_eq("ch3_ready_bad", in_ready3, 3'b000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("ch3_drained", out_valid3, 1'b0);
      check_eq("ch3_hold", out_data3, 4'h5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
